// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver (8N1) with a one-byte holding register.
// Define UART_PARITY_EN to receive an even-parity bit between data and stop.
module uart_rx_os #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a synchronised falling edge
  // START  | qualifying the start bit (glitch reject at mid-bit)
  // DATA   | sampling 8 data bits, LSB first
  // PARITY | sampling the even-parity bit (UART_PARITY_EN only)
  // STOP   | sampling the stop bit, load byte or flag framing error
  // BREAK  | stop bit was low, waiting for the line to return high
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  generate
    if (DIV < 1 || OVERSAMPLE != 16) begin : g_bad_param
      $error("uart_rx_os: CLK_FREQ/(BAUD*16) must be >= 1 and OVERSAMPLE must be 16");
    end
  endgenerate

  logic             sync1, sync2, prev;
  logic [1:0]       settle;
  logic             armed;
  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       samp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             s7, s8;
  logic             tick, mid, last, fall, maj;
  logic             load_now, ferr_now;

`ifdef UART_PARITY_EN
  logic par_err;
`else
  logic par_err;
  assign par_err = 1'b0;
`endif

  assign tick     = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign mid      = tick && (samp_cnt == 4'd9);
  assign last     = tick && (samp_cnt == 4'd15);
  // armed blocks a false start edge while the reset-filled synchroniser drains
  assign fall     = armed && prev && !sync2;
  assign maj      = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
  assign load_now = (state == S_STOP) && mid && maj && !par_err;
  assign ferr_now = (state == S_STOP) && mid && (!maj || par_err);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      settle   <= 2'd0;
      armed    <= 1'b0;
      state    <= S_IDLE;
      div_cnt  <= '0;
      samp_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      s7       <= 1'b1;
      s8       <= 1'b1;
`ifdef UART_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && sync2) armed <= 1'b1;

      if (tick && samp_cnt == 4'd7) s7 <= sync2;
      if (tick && samp_cnt == 4'd8) s8 <= sync2;

      if (state == S_IDLE || tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + 1'b1;

      if (state == S_IDLE) samp_cnt <= 4'd0;
      else if (tick)       samp_cnt <= samp_cnt + 4'd1;

      case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            bit_cnt <= 3'd0;
`ifdef UART_PARITY_EN
            par_err <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (mid && maj) state <= S_IDLE;
          else if (last)  state <= S_DATA;
        end
        S_DATA: begin
          if (mid) shift <= {maj, shift[7:1]};
          if (last) begin
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_PARITY_EN
            if (bit_cnt == 3'd7) state <= S_PARITY;
`else
            if (bit_cnt == 3'd7) state <= S_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (mid)  par_err <= (^shift) ^ maj;
          if (last) state <= S_STOP;
        end
`endif
        S_STOP: begin
          // return at mid-stop so a back-to-back start edge is not missed
          if (mid) state <= maj ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (sync2) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr_now;
      overrun_err <= load_now && rx_valid && !rx_ready;
      if (load_now) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV=2 (32 clocks per bit): table of single
// frames plus hand-written glitch, break, overrun, reset and parity sequences.
module tb_uart_rx_os;

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NBITS  = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NBITS  = 10;
`endif
  localparam int BITC   = 32;
  // rx_valid / error pulse visible at this negedge after the start edge
  localparam int LOAD_N = 23 + BITC * (NBITS - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, busy;

  int checks = 0;
  int errors = 0;
  int ferr_total = 0;
  int ovr_total = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_os #(.CLK_FREQ(50_000_000), .BAUD(1_562_500), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      ferr_total <= ferr_total + int'(frame_err);
      ovr_total  <= ovr_total + int'(overrun_err);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int cycles);
    rxd = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int extra_low);
    drive_bit(1'b0, BITC);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BITC);
    if (PAR_EN) drive_bit(par, BITC);
    drive_bit(stop, BITC);
    if (extra_low > 0) drive_bit(1'b0, extra_low);
    rxd = 1'b1;
  endtask

  task automatic accept(input string name);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check(name, int'(rx_valid), 0);
  endtask

  initial begin
    int f0, o0, busy_hits;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b0};

    // reset held with rxd toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rxd = ~rxd;
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(rx_valid), 0);
      check("rst_data", int'(rx_data), 0);
      check("rst_errs", int'(frame_err) + int'(overrun_err), 0);
    end
    rst = 1'b0;
    rxd = 1'b1;
    repeat (10) @(negedge clk);

    // table of single frames
    for (int v = 0; v < 6; v++) begin
      f0 = ferr_total;
      o0 = ovr_total;
      fork
        send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop, 0);
        begin
          repeat (LOAD_N - 1) @(negedge clk);
          check("vec_pre_load_valid", int'(rx_valid), 0);
          @(negedge clk);
          check("vec_load_valid", int'(rx_valid), int'(vecs[v].exp_valid));
          check("vec_load_ferr", int'(frame_err), int'(vecs[v].exp_ferr));
        end
      join
      repeat (20) @(negedge clk);
      check("vec_busy_idle", int'(busy), 0);
      check("vec_valid_held", int'(rx_valid), int'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) check("vec_data", int'(rx_data), int'(vecs[v].data));
      check("vec_ferr_count", ferr_total - f0, int'(vecs[v].exp_ferr));
      check("vec_ovr_count", ovr_total - o0, 0);
      if (vecs[v].exp_valid) accept("vec_accept");
      repeat (5) @(negedge clk);
    end

    // glitch: 8-cycle low pulse
    f0 = ferr_total;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    check("glitch_busy_n2", int'(busy), 0);
    @(negedge clk);
    check("glitch_busy_n3", int'(busy), 1);
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_valid", int'(rx_valid), 0);
    check("glitch_ferr", ferr_total - f0, 0);

    // framing error followed by a held-low line
    f0 = ferr_total;
    fork
      send_frame(8'h3C, 1'b0, 1'b0, 64);
      begin
        repeat (LOAD_N) @(negedge clk);
        check("break_ferr_pulse", int'(frame_err), 1);
        repeat (BITC * NBITS + 60 - LOAD_N) @(negedge clk);
        check("break_busy_held", int'(busy), 1);
        check("break_ferr_once", ferr_total - f0, 1);
      end
    join
    repeat (10) @(negedge clk);
    check("break_busy_release", int'(busy), 0);
    check("break_ferr_total", ferr_total - f0, 1);
    check("break_valid", int'(rx_valid), 0);

    // back-to-back with no accept: overrun
    o0 = ovr_total;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("ovr_count", ovr_total - o0, 1);
    check("ovr_data", int'(rx_data), 8'h22);
    check("ovr_valid", int'(rx_valid), 1);
    accept("ovr_accept");

    // back-to-back with accept in the load cycle of the second byte
    o0 = ovr_total;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    fork
      send_frame(8'h22, 1'b0, 1'b1, 0);
      begin
        repeat (LOAD_N - 1) @(negedge clk);
        check("simul_old_valid", int'(rx_valid), 1);
        check("simul_old_data", int'(rx_data), 8'h11);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("simul_new_valid", int'(rx_valid), 1);
        check("simul_new_data", int'(rx_data), 8'h22);
        check("simul_ovr_pulse", int'(overrun_err), 0);
      end
    join
    repeat (20) @(negedge clk);
    check("simul_ovr_count", ovr_total - o0, 0);
    accept("simul_accept");

    // reset in mid-frame, line still low after release
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy_in_reset", int'(busy), 0);
    rst = 1'b0;
    busy_hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    check("midrst_no_false_start", busy_hits, 0);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("midrst_valid", int'(rx_valid), 1);
    check("midrst_data", int'(rx_data), 8'h5A);
    accept("midrst_accept");

`ifdef UART_PARITY_EN
    f0 = ferr_total;
    send_frame(8'h07, 1'b1, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("par_good_valid", int'(rx_valid), 1);
    check("par_good_data", int'(rx_data), 8'h07);
    check("par_good_ferr", ferr_total - f0, 0);
    accept("par_good_accept");
    send_frame(8'h07, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("par_bad_ferr", ferr_total - f0, 1);
    check("par_bad_valid", int'(rx_valid), 0);
    check("par_bad_busy", int'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampling UART receiver that deserialises the asynchronous `rxd` line into bytes and presents them on a valid/ready byte interface. It sits directly upstream of the loopback path in `uart_top`. It replaces raw sampling of `rxd` with a synchronised, glitch-filtered, framing-checked front end. One received byte is buffered in a holding register, and overrun and framing errors are reported as single-cycle pulses.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- `OVERSAMPLE`, default 16: samples per bit. The only supported value is 16.

Ports:
- `clk`  in  1  system clock; all logic is synchronous to its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  received byte, valid while `rx_valid` is high.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts the byte on any cycle where `rx_valid` and `rx_ready` are both high.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low, or parity mismatch.
- `overrun_err`  out  1  one-cycle pulse: a new byte was written over an unconsumed byte.
- `busy`  out  1  high in every FSM state except IDLE.

## Operation
- Synchroniser:
  - `rxd` passes through a 2-FF synchroniser; both flops reset to 1.
  - A third flop holds the previous synchronised value for falling-edge detection.
- Tick generator:
  - `DIV = CLK_FREQ / (BAUD*16)`, integer division. `DIV` < 1 is a parameter error.
  - Counter runs 0..DIV-1 and emits a one-cycle `tick` at DIV-1.
  - The counter is cleared on leaving IDLE, so sampling phase is aligned to the start edge.
- Sample counter: 4 bits, 0..15, advances on `tick`. Bit value is the majority of the synchronised samples at counts 7, 8 and 9.
- Bit counter: 3 bits, counts data bits 0..7.
- FSM:
  - IDLE: on a synchronised falling edge, go to START and clear the tick and sample counters.
  - START: at count 9, evaluate the majority. If 1, treat as a glitch and return to IDLE with no error. If 0, continue; at count 15 with tick, go to DATA.
  - DATA: at count 9, shift the majority into bit 7 of the shift register (shift right; LSB first on the line). At count 15, increment the bit counter. After bit 7, go to PARITY if `UART_PARITY_EN` is defined, otherwise to STOP.
  - PARITY: at count 9, check even parity. At count 15, go to STOP.
  - STOP: at count 9, evaluate the majority.
    - If 1 and no parity error: load the byte into the holding register and go to IDLE. The receiver returns at mid-stop-bit so it can catch back-to-back frames.
    - If 0, or a parity error was latched: pulse `frame_err` and discard the byte. A stop bit of 0 goes to BREAK; a parity error with a good stop bit goes to IDLE.
  - BREAK: wait until the synchronised `rxd` is 1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- Holding register:
  - Load while `rx_valid`=1 and no handshake that cycle: overwrite `rx_data`, keep `rx_valid`=1, pulse `overrun_err`.
  - Load in the same cycle as a handshake: new byte replaces the old one, `rx_valid` stays 1, no overrun.
  - Handshake with no load: `rx_valid` goes to 0 on the next edge.
- Reset in mid-frame: FSM goes to IDLE and the partial byte is lost. The next start bit is recognised only after the synchronised line has been seen high and then falls.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, `busy`=0. Synchroniser flops reset to 1.
- Start-edge latency: 2 cycles through the synchroniser plus 1 cycle for edge detect before `busy` rises.
- Load latency: `rx_valid` rises on the clock edge after the tick at count 9 of the stop bit, i.e. about 9.5 bit periods after the line falling edge, plus 3 cycles.
- Error pulses are exactly one `clk` cycle wide, registered, and aligned with the cycle in which `rx_valid` would have risen.
- `rx_ready` is never required to be high. Data is held indefinitely until accepted.

## Configuration
- Macro `UART_PARITY_EN`:
  - Defined: the frame is 1 start, 8 data, 1 even-parity bit, 1 stop. The PARITY state exists. A mismatch pulses `frame_err` and discards the byte.
  - Undefined: the frame is 8N1. The PARITY state and its logic are not compiled in.

## Test plan
Bench parameters: `CLK_FREQ`=50_000_000, `BAUD`=1_562_500 (so `DIV`=2 and one bit = 32 cycles), 20 ns clock. All scenarios use 8N1 unless stated.
- Reset: hold `rst`=1 for 5 cycles with `rxd` toggling. Required: all outputs at their reset values and `busy`=0 throughout.
- Single frame: send 0xA5 with `rx_ready`=0. Required: `rx_data`=0xA5 and `rx_valid`=1 held; `frame_err`=0; `overrun_err`=0. Then raise `rx_ready` for 1 cycle; `rx_valid`=0 on the next cycle.
- Glitch: a 0-pulse of 8 cycles on idle `rxd`. Required: `busy` returns to 0, no `rx_valid`, no `frame_err`.
- Framing error: send 0x3C with the stop bit driven 0, then hold `rxd` low for 64 cycles, then release high. Required: exactly one `frame_err` pulse, `rx_valid` stays 0, and the FSM stays in BREAK until `rxd` is high.
- Overrun and simultaneous accept:
  - Send 0x11 then 0x22 back-to-back with `rx_ready`=0. Required: one `overrun_err` pulse and `rx_data`=0x22.
  - Repeat with `rx_ready` pulsed in the cycle the second byte loads. Required: no `overrun_err`.
- Parity (`UART_PARITY_EN` defined):
  - Send 0x07 with parity bit 1. Required: `rx_data`=0x07, `rx_valid`=1.
  - Send 0x07 with parity bit 0. Required: one `frame_err` pulse and no `rx_valid`.
